// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two write-back requesters, the register-file write
// port and the decode-stage forwarding queries.
`timescale 1ns/1ps
interface regfile_wb_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          a_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          b_valid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] qaddr1;
    logic [AW-1:0] qaddr2;
    logic          qhit1;
    logic          qhit2;
    logic [DW-1:0] qdata1;
    logic [DW-1:0] qdata2;
    logic          idle;

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, qaddr1, qaddr2,
        output a_ready, b_ready, we, waddr, wdata, qhit1, qhit2, qdata1, qdata2, idle
    );

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, qaddr1, qaddr2,
        input  a_ready, b_ready, we, waddr, wdata, qhit1, qhit2, qdata1, qdata2, idle
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-back arbiter: per-requester FIFOs drained round-robin into
// a registered register-file write port, with forwarding of queued writes.
`timescale 1ns/1ps
module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic clk,
    input  logic rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] r_a_addr [DEPTH];
    logic [DW-1:0] r_a_data [DEPTH];
    logic [PW-1:0] r_a_wp, r_a_rp;
    logic [CW-1:0] r_a_cnt;
    logic [AW-1:0] r_b_addr [DEPTH];
    logic [DW-1:0] r_b_data [DEPTH];
    logic [PW-1:0] r_b_wp, r_b_rp;
    logic [CW-1:0] r_b_cnt;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;
    logic          r_last_a;

    logic          w_a_ready, w_b_ready;
    logic          w_a_push, w_b_push;
    logic          w_a_ne, w_b_ne;
    logic          w_gnt_a, w_gnt_b;
    logic [DW:0]   w_q1_a, w_q1_b, w_q2_a, w_q2_b;

    // True when any occupied slot of the FIFO targets register q (q != 0).
    function automatic logic fifo_holds(
        input logic [AW-1:0] q,
        input logic [PW-1:0] rp,
        input logic [CW-1:0] cnt,
        input logic [AW-1:0] addrs [DEPTH]
    );
        logic          hit;
        logic [PW-1:0] idx;
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rp + PW'(k);
            if (CW'(k) < cnt && q != '0 && addrs[idx] == q)
                hit = 1'b1;
        end
        return hit;
    endfunction

    // Scans oldest to youngest so the last match wins; returns {hit, data}.
    function automatic logic [DW:0] fifo_lookup(
        input logic [AW-1:0] q,
        input logic [PW-1:0] rp,
        input logic [CW-1:0] cnt,
        input logic [AW-1:0] addrs [DEPTH],
        input logic [DW-1:0] datas [DEPTH]
    );
        logic [DW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rp + PW'(k);
            if (CW'(k) < cnt && q != '0 && addrs[idx] == q)
                res = {1'b1, datas[idx]};
        end
        return res;
    endfunction

    // Keeping every pending write to one register inside a single FIFO is what
    // preserves program order across the two requesters.
    assign w_a_ready = !rst && (r_a_cnt < FULL)
                     && !fifo_holds(bus.a_addr, r_b_rp, r_b_cnt, r_b_addr);
    assign w_b_ready = !rst && (r_b_cnt < FULL)
                     && !fifo_holds(bus.b_addr, r_a_rp, r_a_cnt, r_a_addr)
                     && !(bus.a_valid && bus.a_addr == bus.b_addr && bus.b_addr != '0);

    assign w_a_push = bus.a_valid && w_a_ready && bus.a_addr != '0;
    assign w_b_push = bus.b_valid && w_b_ready && bus.b_addr != '0;

    assign w_a_ne  = r_a_cnt != '0;
    assign w_b_ne  = r_b_cnt != '0;
    assign w_gnt_a = w_a_ne && (!w_b_ne || !r_last_a);
    assign w_gnt_b = w_b_ne && !w_gnt_a;

    assign w_q1_a = fifo_lookup(bus.qaddr1, r_a_rp, r_a_cnt, r_a_addr, r_a_data);
    assign w_q1_b = fifo_lookup(bus.qaddr1, r_b_rp, r_b_cnt, r_b_addr, r_b_data);
    assign w_q2_a = fifo_lookup(bus.qaddr2, r_a_rp, r_a_cnt, r_a_addr, r_a_data);
    assign w_q2_b = fifo_lookup(bus.qaddr2, r_b_rp, r_b_cnt, r_b_addr, r_b_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_wp   <= '0;
            r_a_rp   <= '0;
            r_a_cnt  <= '0;
            r_b_wp   <= '0;
            r_b_rp   <= '0;
            r_b_cnt  <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_last_a <= 1'b0;
        end else begin
            if (w_a_push) begin
                r_a_addr[r_a_wp] <= bus.a_addr;
                r_a_data[r_a_wp] <= bus.a_data;
                r_a_wp           <= r_a_wp + PW'(1);
            end
            if (w_b_push) begin
                r_b_addr[r_b_wp] <= bus.b_addr;
                r_b_data[r_b_wp] <= bus.b_data;
                r_b_wp           <= r_b_wp + PW'(1);
            end
            if (w_gnt_a)
                r_a_rp <= r_a_rp + PW'(1);
            if (w_gnt_b)
                r_b_rp <= r_b_rp + PW'(1);
            r_a_cnt <= r_a_cnt + CW'(w_a_push) - CW'(w_gnt_a);
            r_b_cnt <= r_b_cnt + CW'(w_b_push) - CW'(w_gnt_b);

            r_we <= w_gnt_a || w_gnt_b;
            if (w_gnt_a) begin
                r_waddr  <= r_a_addr[r_a_rp];
                r_wdata  <= r_a_data[r_a_rp];
                r_last_a <= 1'b1;
            end else if (w_gnt_b) begin
                r_waddr  <= r_b_addr[r_b_rp];
                r_wdata  <= r_b_data[r_b_rp];
                r_last_a <= 1'b0;
            end
        end
    end

    assign bus.a_ready = w_a_ready;
    assign bus.b_ready = w_b_ready;
    assign bus.we      = r_we;
    assign bus.waddr   = r_waddr;
    assign bus.wdata   = r_wdata;
    // At most one FIFO can match a given register, so the hits can be merged.
    assign bus.qhit1   = w_q1_a[DW] || w_q1_b[DW];
    assign bus.qdata1  = w_q1_a[DW] ? w_q1_a[DW-1:0] : w_q1_b[DW-1:0];
    assign bus.qhit2   = w_q2_a[DW] || w_q2_b[DW];
    assign bus.qdata2  = w_q2_a[DW] ? w_q2_a[DW-1:0] : w_q2_b[DW-1:0];
    assign bus.idle    = (r_a_cnt == '0) && (r_b_cnt == '0) && !r_we;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, forwarding, collisions, ordering,
// address-0 discard and sustained round-robin streaming.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_wb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        bus.a_valid = v;
        bus.a_addr  = ad;
        bus.a_data  = d;
    endtask

    task automatic drive_b(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        bus.b_valid = v;
        bus.b_addr  = ad;
        bus.b_data  = d;
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [AW-1:0] ad,
                            input logic [DW-1:0] d);
        chk({tag, ".we"}, 32'(bus.we), 32'(we));
        chk({tag, ".waddr"}, 32'(bus.waddr), 32'(ad));
        chk({tag, ".wdata"}, bus.wdata, d);
    endtask

    logic [AW-1:0] obs_addr [$];
    logic [DW-1:0] obs_data [$];

    initial begin
        int  ia, ib, first_wr, last_wr;
        bit  ta, tb, a_stall;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;

        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        bus.qaddr1 = '0;
        bus.qaddr2 = '0;

        // Reset from power-up, requests offered during reset must not be taken.
        step();
        drive_a(1'b1, 5'd1, 32'h1);
        drive_b(1'b1, 5'd2, 32'h2);
        #1;
        chk("rst.a_ready", 32'(bus.a_ready), 32'd0);
        chk("rst.b_ready", 32'(bus.b_ready), 32'd0);
        step();
        rst = 1'b0;
        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        #1;
        chk_port("rst0", 1'b0, '0, '0);
        chk("rst0.idle", 32'(bus.idle), 32'd1);

        // A alone writes r3=0x11.
        drive_a(1'b1, 5'd3, 32'h11);
        #1;
        chk("a3.a_ready", 32'(bus.a_ready), 32'd1);
        step();
        drive_a(1'b0, '0, '0);
        bus.qaddr1 = 5'd3;
        #1;
        chk("a3.qhit1", 32'(bus.qhit1), 32'd1);
        chk("a3.qdata1", bus.qdata1, 32'h11);
        chk("a3.we_early", 32'(bus.we), 32'd0);
        step();
        chk_port("a3.port", 1'b1, 5'd3, 32'h11);
        chk("a3.qhit1_after", 32'(bus.qhit1), 32'd0);
        step();
        chk_port("a3.hold", 1'b0, 5'd3, 32'h11);
        chk("a3.idle", 32'(bus.idle), 32'd1);

        // Write to r0 is accepted and discarded.
        drive_a(1'b1, 5'd0, 32'hFF);
        bus.qaddr1 = 5'd0;
        #1;
        chk("r0.a_ready", 32'(bus.a_ready), 32'd1);
        chk("r0.qhit1", 32'(bus.qhit1), 32'd0);
        step();
        drive_a(1'b0, '0, '0);
        #1;
        chk("r0.idle", 32'(bus.idle), 32'd1);
        chk("r0.qhit1_q", 32'(bus.qhit1), 32'd0);
        chk("r0.qdata1_q", bus.qdata1, 32'h0);
        step();
        chk("r0.we", 32'(bus.we), 32'd0);

        // Same-cycle collision on r5: A goes first, B waits for A's r5 to drain.
        drive_a(1'b1, 5'd5, 32'hAA);
        drive_b(1'b1, 5'd5, 32'hBB);
        bus.qaddr2 = 5'd5;
        #1;
        chk("col.a_ready", 32'(bus.a_ready), 32'd1);
        chk("col.b_ready", 32'(bus.b_ready), 32'd0);
        step();
        drive_a(1'b0, '0, '0);
        #1;
        chk("col.b_blocked", 32'(bus.b_ready), 32'd0);
        chk("col.qdata2_aa", bus.qdata2, 32'hAA);
        step();
        chk_port("col.wrA", 1'b1, 5'd5, 32'hAA);
        chk("col.b_ready_free", 32'(bus.b_ready), 32'd1);
        step();
        drive_b(1'b0, '0, '0);
        #1;
        chk("col.qhit2_bb", 32'(bus.qhit2), 32'd1);
        chk("col.qdata2_bb", bus.qdata2, 32'hBB);
        step();
        chk_port("col.wrB", 1'b1, 5'd5, 32'hBB);

        // A queues r7=1 then r7=2 while B competes for the port.
        drive_a(1'b1, 5'd30, 32'h30);
        bus.qaddr1 = 5'd7;
        step();
        drive_a(1'b1, 5'd7, 32'h1);
        drive_b(1'b1, 5'd20, 32'h20);
        step();
        chk_port("r7.wr30", 1'b1, 5'd30, 32'h30);
        chk("r7.qdata_first", bus.qdata1, 32'h1);
        drive_a(1'b1, 5'd7, 32'h2);
        drive_b(1'b1, 5'd21, 32'h21);
        #1;
        chk("r7.a_ready", 32'(bus.a_ready), 32'd1);
        step();
        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        #1;
        chk_port("r7.wr20", 1'b1, 5'd20, 32'h20);
        chk("r7.qhit_young", 32'(bus.qhit1), 32'd1);
        chk("r7.qdata_young", bus.qdata1, 32'h2);
        step();
        chk_port("r7.wr7a", 1'b1, 5'd7, 32'h1);
        chk("r7.qdata_left", bus.qdata1, 32'h2);
        step();
        chk_port("r7.wr21", 1'b1, 5'd21, 32'h21);
        step();
        chk_port("r7.wr7b", 1'b1, 5'd7, 32'h2);
        step();
        chk("r7.we_end", 32'(bus.we), 32'd0);
        chk("r7.idle", 32'(bus.idle), 32'd1);

        // Reset with both FIFOs partly full drops all queued writes.
        drive_a(1'b1, 5'd2, 32'h2);
        drive_b(1'b1, 5'd4, 32'h4);
        step();
        drive_a(1'b1, 5'd3, 32'h3);
        drive_b(1'b1, 5'd6, 32'h6);
        step();
        rst = 1'b1;
        #1;
        chk("mrst.a_ready", 32'(bus.a_ready), 32'd0);
        chk("mrst.b_ready", 32'(bus.b_ready), 32'd0);
        step();
        rst = 1'b0;
        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        bus.qaddr1 = 5'd4;
        #1;
        chk_port("mrst.port", 1'b0, '0, '0);
        chk("mrst.idle", 32'(bus.idle), 32'd1);
        chk("mrst.qhit1", 32'(bus.qhit1), 32'd0);
        step();
        chk("mrst.we_next", 32'(bus.we), 32'd0);

        // Both requesters streaming: port alternates A,B at one write per cycle.
        ia = 0;
        ib = 0;
        first_wr = -1;
        last_wr = -1;
        a_stall = 1'b0;
        for (int cyc = 0; cyc < 100 && obs_addr.size() < 16; cyc++) begin
            drive_a(ia < 8, AW'(ia + 1), DW'(32'h100 + ia + 1));
            drive_b(ib < 8, AW'(ib + 9), DW'(32'h200 + ib + 9));
            #1;
            ta = bus.a_valid && bus.a_ready;
            tb = bus.b_valid && bus.b_ready;
            if (bus.a_valid && !bus.a_ready)
                a_stall = 1'b1;
            step();
            if (ta) ia++;
            if (tb) ib++;
            if (bus.we) begin
                obs_addr.push_back(bus.waddr);
                obs_data.push_back(bus.wdata);
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
        end
        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        chk("stream.count", 32'(obs_addr.size()), 32'd16);
        chk("stream.span", 32'(last_wr - first_wr), 32'd15);
        chk("stream.a_stalled", 32'(a_stall), 32'd1);
        for (int k = 0; k < obs_addr.size() && k < 16; k++) begin
            if (k % 2 == 0) begin
                ea = AW'(k / 2 + 1);
                ed = 32'h100 + 32'(ea);
            end else begin
                ea = AW'(9 + k / 2);
                ed = 32'h200 + 32'(ea);
            end
            chk($sformatf("stream.addr%0d", k), 32'(obs_addr[k]), 32'(ea));
            chk($sformatf("stream.data%0d", k), obs_data[k], ed);
        end
        step();
        chk("stream.idle", 32'(bus.idle), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
